// File: rtl/char_loader.sv
// -----------------------------------------------------------------------------
// char_loader
//
// Upstream feeder for the embedding layer. Character codes arrive one per beat
// over a valid/ready handshake and are packed into an N-slot frame; a short
// sequence (closed early by s_last) is padded with PAD_ID. When the frame is
// complete it is presented on d together with a one-cycle run pulse. The frame
// is then held until the embedding layer raises done, after which the loader
// clears the frame and accepts the next sequence. Filling and computing never
// overlap.
//
// Handshake: a beat transfers on a rising clk edge where s_valid & s_ready are
// both high. s_ready depends only on internal state (never on s_valid). An
// upstream source that sees s_ready low must hold its beat and retry; s_data
// and s_last are ignored whenever s_ready is low.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous, active-high reset
//   s_valid  in   input character valid
//   s_ready  out  loader can accept a character this cycle (FILL only)
//   s_data   in   input character code [CHAR_LEN]
//   s_last   in   last character of a sequence
//   run      out  one-cycle start pulse to the embedding layer
//   d        out  packed frame, slot k at d[k*CHAR_LEN +: CHAR_LEN]
//   done     in   embedding layer result valid (level; a rising edge ends WAIT)
//   busy     out  frame issued, waiting for done
//   err      out  sticky illegal-code flag (only with range checking built in)
//
// Build option:
//   CHAR_LOADER_RANGE_CHECK_EN - when defined, an accepted code of 0 or above
//   VOCAB is stored as UNK_ID and sets the sticky err output. When undefined,
//   codes are stored unmodified and err is not present.
// -----------------------------------------------------------------------------
module char_loader #(
    parameter int N        = 10,
    parameter int CHAR_LEN = 8,
    parameter int VOCAB    = 200,
    parameter int PAD_ID   = 0,
    parameter int UNK_ID   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CHAR_LEN-1:0]   s_data,
    input  logic                  s_last,
    output logic                  run,
    output logic [N*CHAR_LEN-1:0] d,
    input  logic                  done,
    output logic                  busy
`ifdef CHAR_LOADER_RANGE_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]       LAST_SLOT = CW'(N - 1);
    localparam logic [CHAR_LEN-1:0] PAD_C     = CHAR_LEN'(PAD_ID);

    // Elaboration-time sanity checks on the configuration.
    if (VOCAB > (1 << CHAR_LEN) - 1 || VOCAB < 1) begin : g_bad_vocab
        $error("char_loader: VOCAB must lie in 1..2**CHAR_LEN-1");
    end
    if (UNK_ID < 1 || UNK_ID > VOCAB) begin : g_bad_unk
        $error("char_loader: UNK_ID must be a legal code");
    end

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       cnt;
    logic [CHAR_LEN-1:0] slot [N];
    logic                ready_q;    // low until the first edge after reset
    logic                done_q;
    logic                accept;
    logic                close;
    logic                done_rise;
    logic [CHAR_LEN-1:0] code;

    // accept is built from state directly rather than from s_ready so that the
    // FSM output block below has no combinational feedback.
    assign accept    = s_valid & ready_q & (state == ST_FILL);
    assign close     = accept & (s_last | (cnt == LAST_SLOT));
    assign done_rise = done & ~done_q;

`ifdef CHAR_LOADER_RANGE_CHECK_EN
    localparam logic [CHAR_LEN-1:0] VOCAB_C = CHAR_LEN'(VOCAB);
    localparam logic [CHAR_LEN-1:0] UNK_C   = CHAR_LEN'(UNK_ID);
    logic illegal;
    assign illegal = (s_data == '0) | (s_data > VOCAB_C);
    assign code    = illegal ? UNK_C : s_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && illegal) begin
            err <= 1'b1;
        end
    end
`else
    assign code = s_data;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        run        = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_FILL: begin
                s_ready = ready_q;
                if (close) state_next = ST_RUN;
            end
            ST_RUN: begin
                run        = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (done_rise) state_next = ST_FILL;
            end
            default: state_next = ST_FILL;
        endcase
    end

    // Frame storage, slot counter and done history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            cnt     <= '0;
            for (int k = 0; k < N; k++) slot[k] <= PAD_C;
        end else begin
            ready_q <= 1'b1;
            // done is tracked every cycle, so a level still high from the
            // previous frame is already in done_q when WAIT is entered.
            done_q  <= done;
            if (accept) begin
                cnt <= cnt + 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (CW'(k) == cnt) begin
                        slot[k] <= code;
                    end else if (close && (CW'(k) > cnt)) begin
                        slot[k] <= PAD_C;
                    end
                end
            end else if ((state == ST_WAIT) && done_rise) begin
                cnt <= '0;
                for (int k = 0; k < N; k++) slot[k] <= PAD_C;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign d[g*CHAR_LEN +: CHAR_LEN] = slot[g];
    end

endmodule
